// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and a helper for
// deriving the bit period from the system clock and baud rate.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    // Rounded to the nearest whole clock so the baud error stays symmetric.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_tick on the last
// count. clear restarts the period so the bit phase can be aligned to a frame.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_tick = (cnt_q == TERM);
    assign cnt_d    = (clear || bit_tick) ? '0 : cnt_q + 1'b1;

    // NOTE: clocked state is always written with <= so every flop samples
    // the values from before the edge, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a 1-cycle-latency synchronous FIFO and sends each one as a
// UART frame (start, DATA_WIDTH bits LSB first, STOP_BITS stop bits).
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BCW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    uart_tx_state_t        state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  bit_tick;
    logic                  baud_clear;
    logic                  stop_last;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    assign stop_last  = (state_q == STOP) && bit_tick && (bit_cnt_q == LAST_STOP);
    // Popping in the final stop cycle lets LOAD absorb the FIFO read latency.
    assign fifo_rd_en = ~rst & ~fifo_empty & tx_en & ((state_q == IDLE) | stop_last);
    assign frame_done = stop_last;
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_rd_en) state_d = LOAD;
            end
            LOAD: begin
                shift_d    = fifo_data_out;
                bit_cnt_d  = '0;
                baud_clear = 1'b1;
                state_d    = START;
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = fifo_rd_en ? LOAD : IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so tx moves on the state edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a model FIFO with 1-cycle read latency, a tx-line
// decoder feeding a byte scoreboard, table-driven frames and corner sequences.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data_out = 8'h00;
    logic       fifo_rd_en, tx, busy, frame_done;

    logic       fifo2_empty = 1'b1;
    logic [7:0] fifo2_data_out = 8'h55;
    logic       fifo2_rd_en, tx2, busy2, frame_done2;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .tx(tx),
        .busy(busy), .frame_done(frame_done)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo2_empty),
        .fifo_data_out(fifo2_data_out), .fifo_rd_en(fifo2_rd_en), .tx(tx2),
        .busy(busy2), .frame_done(frame_done2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model FIFO: a pop requested in cycle N presents its byte during cycle N+1.
    logic [7:0] fifo_q[$];
    logic       rd_q = 1'b0;

    always @(posedge clk) rd_q <= fifo_rd_en;

    always @(negedge clk) begin
        if (rd_q) begin
            if (fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // Line decoder and scoreboard of bytes expected on tx.
    logic [7:0] exp_q[$];
    logic       mon_active = 1'b0;
    logic       tx_prev = 1'b1;
    int         mcnt = 0;
    logic [7:0] mbyte = 8'h00;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx_prev === 1'b1 && tx === 1'b0) begin
                mon_active = 1'b1;
                mcnt       = 0;
                mbyte      = 8'h00;
            end
        end else begin
            mcnt++;
            for (int i = 0; i < 8; i++)
                if (mcnt == CPB * (i + 1) + CPB / 2) mbyte[i] = tx;
            if (mcnt == CPB * 9 + CPB / 2) begin
                check("sb_stop_bit", 64'(tx), 64'd1);
                if (exp_q.size() == 0) check("sb_unexpected_frame", 64'(mbyte), 64'hFFFF);
                else check("sb_byte", 64'(mbyte), 64'(exp_q.pop_front()));
            end
            if (mcnt == CPB * 10 - 1) mon_active = 1'b0;
        end
        tx_prev = tx;
    end

    logic tr_tx[0:127], tr_rd[0:127], tr_busy[0:127], tr_fd[0:127];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Records n cycles starting at the current sample point; optionally drops tx_en.
    task automatic capture(input int n, input int drop_at);
        for (int c = 0; c < n; c++) begin
            if (c > 0) tick();
            tr_tx[c]   = tx;
            tr_rd[c]   = fifo_rd_en;
            tr_busy[c] = busy;
            tr_fd[c]   = frame_done;
            if (c == drop_at) tx_en = 1'b0;
        end
    endtask

    function automatic logic [63:0] expand(input logic [15:0] frame, input int nbits);
        logic [63:0] r = '0;
        for (int k = 0; k < nbits * CPB; k++) r[k] = frame[k / CPB];
        return r;
    endfunction

    function automatic logic [63:0] trace_tx(input int c0, input int len);
        logic [63:0] r = '0;
        for (int k = 0; k < len; k++)
            if (c0 + k >= 0 && c0 + k < 128) r[k] = tr_tx[c0 + k];
        return r;
    endfunction

    function automatic logic [63:0] trace_fd(input int c0, input int len);
        logic [63:0] r = '0;
        for (int k = 0; k < len; k++)
            if (c0 + k >= 0 && c0 + k < 128) r[k] = tr_fd[c0 + k];
        return r;
    endfunction

    function automatic int count_rd(input int n);
        int s = 0;
        for (int c = 0; c < n; c++) if (tr_rd[c] === 1'b1) s++;
        return s;
    endfunction

    function automatic int count_busy(input int n);
        int s = 0;
        for (int c = 0; c < n; c++) if (tr_busy[c] === 1'b1) s++;
        return s;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit 0 = start bit, bit 9 = stop bit
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tx2_tr[0:63];
        logic fd2_tr[0:63];
        logic [63:0] v;
        int r2, f1, s1, s2, bad;

        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h3C, 10'h278};
        vecs[2] = '{8'h81, 10'h302};
        vecs[3] = '{8'hFF, 10'h3FE};
        vecs[4] = '{8'h6E, 10'h2DC};

        // Reset state
        rst   = 1'b1;
        tx_en = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {tx, busy, fifo_rd_en, frame_done}, 4'b1000);
        check("reset_outputs_2stop", {tx2, busy2, fifo2_rd_en, frame_done2}, 4'b1000);
        rst   = 1'b0;
        tx_en = 1'b1;
        tick();
        check("idle_outputs", {tx, busy, fifo_rd_en, frame_done}, 4'b1000);

        // Single frames from the table
        foreach (vecs[i]) begin
            push(vecs[i].data);
            exp_q.push_back(vecs[i].data);
            #1;
            capture(43, -1);
            check($sformatf("v%0d_rd_first", i), 64'(tr_rd[0]), 64'd1);
            check($sformatf("v%0d_load_cycle", i), {tr_tx[1], tr_busy[1], tr_rd[1]}, 3'b110);
            check($sformatf("v%0d_tx_frame", i), trace_tx(2, 40), expand(16'(vecs[i].frame), 10));
            check($sformatf("v%0d_frame_done_pos", i), trace_fd(2, 40), 64'd1 << 39);
            check($sformatf("v%0d_busy_cycles", i), 64'(count_busy(43)), 64'd41);
            check($sformatf("v%0d_rd_count", i), 64'(count_rd(43)), 64'd1);
            check($sformatf("v%0d_idle_after", i), {tr_tx[42], tr_busy[42]}, 2'b10);
        end

        // Back-to-back frames
        push(8'h00);
        push(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        #1;
        capture(90, -1);
        r2 = -1; f1 = -1; s1 = -1; s2 = -1;
        for (int c = 1; c < 90; c++) begin
            if (tr_rd[c] === 1'b1 && r2 < 0) r2 = c;
            if (tr_fd[c] === 1'b1 && f1 < 0) f1 = c;
            if (tr_tx[c-1] === 1'b1 && tr_tx[c] === 1'b0) begin
                if (s1 < 0) s1 = c;
                else if (s2 < 0) s2 = c;
            end
        end
        check("b2b_rd_count", 64'(count_rd(90)), 64'd2);
        check("b2b_second_rd_cycle", 64'(r2), 64'd41);
        check("b2b_first_done_cycle", 64'(f1), 64'd41);
        check("b2b_start_spacing", 64'(s2 - s1), 64'd41);
        check("b2b_frame1_data", trace_tx(6, 32), 64'd0);
        check("b2b_frame2_data", trace_tx(s2 + 4, 32), 64'hFFFF_FFFF);

        // Empty FIFO with tx_en high
        capture(100, -1);
        bad = 0;
        for (int c = 0; c < 100; c++)
            if (tr_rd[c] !== 1'b0 || tr_tx[c] !== 1'b1 || tr_busy[c] !== 1'b0) bad++;
        check("empty_quiet_cycles", 64'(bad), 64'd0);

        // tx_en dropped during data bit 2
        push(8'h3C);
        push(8'h5A);
        exp_q.push_back(8'h3C);
        #1;
        capture(60, 15);
        check("txen_rd_count", 64'(count_rd(60)), 64'd1);
        check("txen_frame_intact", trace_tx(2, 40), expand(16'h278, 10));
        check("txen_idle_after", {tr_tx[59], tr_busy[59]}, 2'b10);
        check("txen_byte_kept", 64'(fifo_q.size()), 64'd1);
        tx_en = 1'b1;
        exp_q.push_back(8'h5A);
        #1;
        capture(43, -1);
        check("txen_rd_after_reenable", 64'(tr_rd[0]), 64'd1);
        check("txen_second_frame", trace_tx(2, 40), expand(16'h2B4, 10));

        // Reset during data bit 4
        push(8'h81);
        #1;
        check("rst_rd_first", 64'(fifo_rd_en), 64'd1);
        repeat (23) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_midframe_outputs", {tx, busy, fifo_rd_en, frame_done}, 4'b1000);
        capture(10, -1);
        check("rst_line_stays_high", trace_tx(0, 10), 64'h3FF);
        push(8'h6E);
        exp_q.push_back(8'h6E);
        #1;
        capture(43, -1);
        check("rst_next_rd", 64'(tr_rd[0]), 64'd1);
        check("rst_next_frame", trace_tx(2, 40), expand(16'h2DC, 10));
        check("rst_next_done_pos", trace_fd(2, 40), 64'd1 << 39);

        // Two stop bits
        fifo2_empty = 1'b0;
        #1;
        check("stop2_rd_first", 64'(fifo2_rd_en), 64'd1);
        bad = 0;
        for (int c = 1; c < 48; c++) begin
            tick();
            if (c == 1) fifo2_empty = 1'b1;
            tx2_tr[c] = tx2;
            fd2_tr[c] = frame_done2;
            if (fifo2_rd_en !== 1'b0) bad++;
        end
        v = '0;
        for (int k = 0; k < 44; k++) v[k] = tx2_tr[k + 2];
        check("stop2_tx_frame", v, expand(16'h6AA, 11));
        v = '0;
        for (int k = 0; k < 44; k++) v[k] = fd2_tr[k + 2];
        check("stop2_frame_done_pos", v, 64'd1 << 43);
        check("stop2_idle_after", {tx2, busy2}, 2'b10);
        check("stop2_no_extra_rd", 64'(bad), 64'd0);

        repeat (5) tick();
        check("sb_all_bytes_seen", 64'(exp_q.size()), 64'd0);
        check("fifo_drained", 64'(fifo_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drains bytes from the read port of a synchronous FIFO and serialises each one onto a UART TX line: 8N1 by default, 1 or 2 stop bits.
- Sits directly downstream of the FIFO. It owns the FIFO's rd_en, and it watches the FIFO's empty flag and read data.
- The FIFO read data is valid one cycle after rd_en is asserted, and this block accounts for that latency.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (same as FIFO DATA_WIDTH).
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Must be >= 2.
- STOP_BITS, 1, number of stop bits. Legal values are 1 or 2.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset, synchronous, active-high.
- tx_en  input  1  1 allows new frames to start. A frame already in progress always completes.
- fifo_empty  input  1  empty flag from the FIFO.
- fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  pop request to the FIFO. Single-cycle pulse per byte.
- tx  output  1  serial line. Idles high.
- busy  output  1  1 whenever the state is not IDLE.
- frame_done  output  1  single-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset:
  - Sampled on the rising clk edge while rst=1.
  - Reset values: state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, all counters 0, shift register 0.
- Reset mid-frame:
  - tx=1 from the first edge with rst=1. The partial frame is abandoned.
  - The byte already popped is lost; it is not re-read.
- fifo_rd_en is combinational. It is 1 only when ~fifo_empty & tx_en & (state==IDLE, or state==STOP in the last cycle of the final stop bit). It is never asserted while fifo_empty=1.
- tx is a register, loaded from next-state logic so that tx changes on the same edge that the state changes.
- States and transitions:
  - IDLE: tx=1. If fifo_rd_en=1, go to LOAD.
  - LOAD (1 cycle): shift_reg <= fifo_data_out. tx stays 1. Go to START, with tx <= 0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit, then shift right. Bits are sent LSB first. After DATA_WIDTH bits, go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. In the last cycle, frame_done=1. If fifo_rd_en=1 in that cycle, go to LOAD; otherwise go to IDLE.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1, wraps to 0, and emits bit_tick on the terminal count.
  - The baud counter is cleared on entry to START, so the bit phase always aligns to the frame.
  - Bit counter is $clog2(DATA_WIDTH)+1 bits and is used in DATA and STOP.
- Timing:
  - If fifo_rd_en=1 in cycle N, tx falls at cycle N+2.
  - Frame length is (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
  - Back-to-back frames: the next start bit begins STOP_BITS*CLKS_PER_BIT+1 cycles after the stop bit starts, i.e. one extra idle-high cycle spent in LOAD.
- tx_en:
  - Only gates the start of a new frame.
  - Dropping tx_en mid-frame has no effect on that frame; the block returns to IDLE afterwards.
- FIFO going empty during STOP: the block returns to IDLE with no rd_en pulse.
- busy=1 in LOAD, START, DATA and STOP.

Decomposition:
- Shared package uart_pkg holds:
  - the typedef enum logic [2:0] uart_tx_state_t {IDLE, LOAD, START, DATA, STOP};
  - the function clks_per_bit(clk_hz, baud) for computing the parameter at integration.
- One sub-module, uart_baud_gen:
  - Parameter CLKS_PER_BIT.
  - Ports: clk, rst, clear, bit_tick.
  - Reused by the future uart_rx.
- The top-level FSM, shift register and bit counter stay in fifo_uart_tx.

Test Plan:
All scenarios use DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1, driven by a model FIFO with 1-cycle read latency.
1. Single byte:
   - Stimulus: push 0xA5, tx_en=1.
   - Response: one rd_en pulse. Two cycles later tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles.
   - frame_done is 1 at frame cycle 39. busy=1 for 41 cycles total.
2. Back-to-back:
   - Stimulus: push 0x00 then 0xFF.
   - Response: the second rd_en coincides with the first frame_done. The second start bit begins exactly 41 cycles after the first.
   - tx during the second frame's data bits is all 1.
3. Empty FIFO:
   - Stimulus: tx_en=1, FIFO empty for 100 cycles.
   - Response: fifo_rd_en=0, tx=1 and busy=0 throughout.
4. tx_en drop:
   - Stimulus: push 0x3C and 0x5A. Deassert tx_en during data bit 2 of the first frame.
   - Response: the 0x3C frame completes intact, no second rd_en, the block returns to IDLE with 0x5A still in the FIFO.
   - Re-assert tx_en: 0x5A then transmits.
5. Reset mid-frame:
   - Stimulus: assert rst for 1 cycle during data bit 4 of 0x81.
   - Response: the next cycle has tx=1, busy=0, fifo_rd_en=0.
   - With a pending byte, the next frame starts cleanly from IDLE.
6. STOP_BITS=2 run:
   - Stimulus: push 0x55.
   - Response: the stop high lasts 8 cycles, and frame_done is 1 at frame cycle 43.
